// File: rtl/crc_stream_engine.sv
// crc_stream_engine: parallel CRC generator for framed valid/ready streams.
// Folds DATA_W bits per accepted beat into a CRC_W-bit LFSR state and holds
// the finished frame CRC until the consumer takes it.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        input beat handshake (in_ready registered from state)
//   in_data[DATA_W]          beat, byte 0 = in_data[DATA_W-1 -: 8] folded first
//   in_sof/in_eof            frame delimiters (both on one beat = 1-beat frame)
//   out_valid/out_ready      result handshake, out_crc stable while out_valid
//   out_crc[CRC_W]           (REFOUT ? rev(reg) : reg) ^ XOR_OUT
//   frame_err                one-cycle pulse on a protocol violation
//   out_ok                   only with CRC_STREAM_CHECK_EN: pre-XOR_OUT reg == RESIDUE
//
// Optional feature macro: CRC_STREAM_CHECK_EN (adds out_ok and the residue compare).
module crc_stream_engine #(
  parameter int unsigned CRC_W   = 16,
  parameter int unsigned DATA_W  = 8,
  parameter logic [31:0] POLY    = 32'h0000_1021,
  parameter logic [31:0] INIT    = 32'h0000_FFFF,
  parameter logic [31:0] XOR_OUT = 32'h0000_0000,
  parameter bit          REFIN   = 1'b0,
  parameter bit          REFOUT  = 1'b0,
  parameter logic [31:0] RESIDUE = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc,
  output logic              frame_err
`ifdef CRC_STREAM_CHECK_EN
  ,
  output logic              out_ok
`endif
);

  localparam int unsigned NBYTES = DATA_W / 8;

  localparam logic [CRC_W-1:0] POLY_C = CRC_W'(POLY);
  localparam logic [CRC_W-1:0] INIT_C = CRC_W'(INIT);
  localparam logic [CRC_W-1:0] XOR_C  = CRC_W'(XOR_OUT);
`ifdef CRC_STREAM_CHECK_EN
  localparam logic [CRC_W-1:0] RES_C  = CRC_W'(RESIDUE);
`endif

  // Elaboration-time parameter sanity.
  if (CRC_W < 8 || CRC_W > 32) begin : g_bad_crc_w
    $error("crc_stream_engine: CRC_W=%0d outside 8..32", CRC_W);
  end
  if (DATA_W < 8 || DATA_W > 64 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("crc_stream_engine: DATA_W=%0d must be a multiple of 8 in 8..64", DATA_W);
  end
  // Set bits above CRC_W in the constants are dropped; flag it as a likely typo.
  if ((POLY >> CRC_W) != 32'd0 || (INIT >> CRC_W) != 32'd0 ||
      (XOR_OUT >> CRC_W) != 32'd0 || (RESIDUE >> CRC_W) != 32'd0) begin : g_trunc_warn
    $warning("crc_stream_engine: constant bits above CRC_W=%0d are truncated", CRC_W);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CRC_W-1:0]   out_crc_q, out_crc_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               frame_err_q, frame_err_d;
`ifdef CRC_STREAM_CHECK_EN
  logic               out_ok_q, out_ok_d;
`endif

  logic               accept_c;
  logic [CRC_W-1:0]   fold_src_c;
  logic [CRC_W-1:0]   fold_res_c;

  // Bit-reverse one byte.
  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = '0;
    s = x;
    for (int unsigned k = 0; k < 8; k++) begin
      r = {r[6:0], s[0]};
      s = s >> 1;
    end
    return r;
  endfunction

  // Bit-reverse the full CRC word.
  function automatic logic [CRC_W-1:0] rev_crc(input logic [CRC_W-1:0] x);
    logic [CRC_W-1:0] r;
    logic [CRC_W-1:0] s;
    r = '0;
    s = x;
    for (int unsigned k = 0; k < CRC_W; k++) begin
      r = {r[CRC_W-2:0], s[0]};
      s = s >> 1;
    end
    return r;
  endfunction

  // Unrolled MSB-first LFSR over every byte of the beat, byte 0 first.
  function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] crc_in,
                                            input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic [7:0]       b;
    logic             fb;
    c = crc_in;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      b = 8'(data >> (DATA_W - 8 * (i + 1)));
      if (REFIN) b = rev8(b);
      for (int unsigned j = 0; j < 8; j++) begin
        fb = c[CRC_W-1] ^ b[7];
        b  = b << 1;
        c  = {c[CRC_W-2:0], 1'b0};
        if (fb) c = c ^ POLY_C;
      end
    end
    return c;
  endfunction

  // Fold path: a sof beat (or any beat seen from IDLE) restarts from INIT.
  always_comb begin
    accept_c   = in_valid && in_ready_q;
    fold_src_c = (state_q == S_IDLE || in_sof) ? INIT_C : crc_q;
    fold_res_c = fold(fold_src_c, in_data);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    out_crc_d   = out_crc_q;
    frame_err_d = 1'b0;
`ifdef CRC_STREAM_CHECK_EN
    out_ok_d    = out_ok_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (in_sof) begin
            crc_d   = fold_res_c;
            state_d = in_eof ? S_HOLD : S_RUN;
          end else begin
            // Beat outside a frame: swallowed and flagged.
            frame_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept_c) begin
          crc_d = fold_res_c;
          // sof mid-frame abandons the open frame; fold_src_c already chose INIT.
          if (in_sof) frame_err_d = 1'b1;
          if (in_eof) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Latch the finished result on the eof fold so it is stable through HOLD.
    if (state_q != S_HOLD && state_d == S_HOLD) begin
      out_crc_d = (REFOUT ? rev_crc(fold_res_c) : fold_res_c) ^ XOR_C;
`ifdef CRC_STREAM_CHECK_EN
      out_ok_d  = (fold_res_c == RES_C);
`endif
    end

    in_ready_d  = (state_d != S_HOLD);
    out_valid_d = (state_d == S_HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      crc_q       <= INIT_C;
      out_crc_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef CRC_STREAM_CHECK_EN
      out_ok_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      out_crc_q   <= out_crc_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      frame_err_q <= frame_err_d;
`ifdef CRC_STREAM_CHECK_EN
      out_ok_q    <= out_ok_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_crc   = out_crc_q;
  assign frame_err = frame_err_q;
`ifdef CRC_STREAM_CHECK_EN
  assign out_ok    = out_ok_q;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine. Instance A: CRC-16/CCITT-FALSE, 8-bit beats.
// Instance B: CRC-16/ARC, 8-bit beats, same input stream as A.
// Instance C: CCITT-FALSE with 16-bit beats.
module tb_crc_stream_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_data = '0;
  logic        a_in_ready, a_out_valid, a_frame_err;
  logic [15:0] a_out_crc;
  logic        b_in_ready, b_out_valid, b_frame_err;
  logic [15:0] b_out_crc;
  logic        c_in_valid = 1'b0, c_in_sof = 1'b0, c_in_eof = 1'b0, c_out_ready = 1'b0;
  logic [15:0] c_in_data = '0;
  logic        c_in_ready, c_out_valid, c_frame_err;
  logic [15:0] c_out_crc;
`ifdef CRC_STREAM_CHECK_EN
  logic        a_out_ok, b_out_ok, c_out_ok;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  logic [7:0] fbytes[$];

  always #5 clk = ~clk;

  crc_stream_engine #(.CRC_W(16), .DATA_W(8), .POLY(32'h0000_1021), .INIT(32'h0000_FFFF),
                      .XOR_OUT(32'h0), .REFIN(1'b0), .REFOUT(1'b0), .RESIDUE(32'h0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_crc(a_out_crc), .frame_err(a_frame_err)
`ifdef CRC_STREAM_CHECK_EN
    , .out_ok(a_out_ok)
`endif
  );

  crc_stream_engine #(.CRC_W(16), .DATA_W(8), .POLY(32'h0000_8005), .INIT(32'h0),
                      .XOR_OUT(32'h0), .REFIN(1'b1), .REFOUT(1'b1), .RESIDUE(32'h0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_crc(b_out_crc), .frame_err(b_frame_err)
`ifdef CRC_STREAM_CHECK_EN
    , .out_ok(b_out_ok)
`endif
  );

  crc_stream_engine #(.CRC_W(16), .DATA_W(16), .POLY(32'h0000_1021), .INIT(32'h0000_FFFF),
                      .XOR_OUT(32'h0), .REFIN(1'b0), .REFOUT(1'b0), .RESIDUE(32'h0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_sof(c_in_sof), .in_eof(c_in_eof), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_crc(c_out_crc), .frame_err(c_frame_err)
`ifdef CRC_STREAM_CHECK_EN
    , .out_ok(c_out_ok)
`endif
  );

  always @(negedge clk) if (a_frame_err) err_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] actv, input logic [31:0] expv);
    n_checks++;
    if (actv !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actv, expv);
    end
  endtask

  function automatic logic [31:0] rev_n(input logic [31:0] x, input int w);
    logic [31:0] r;
    logic [31:0] s;
    r = '0;
    s = x;
    for (int k = 0; k < w; k++) begin
      r = (r << 1) | (s & 32'd1);
      s = s >> 1;
    end
    return r;
  endfunction

  // Textbook CRC over fbytes: MSB-first shift-left, or reflected shift-right form.
  function automatic logic [31:0] model_crc(input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input logic [31:0] xo,
                                            input bit refin, input bit refout);
    logic [31:0] mask, r, rp, res;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (!refin) begin
      r = init & mask;
      foreach (fbytes[k]) begin
        r = r ^ (32'(fbytes[k]) << (w - 8));
        for (int b = 0; b < 8; b++)
          r = (((r >> (w - 1)) & 32'd1) != 0) ? (((r << 1) ^ poly) & mask) : ((r << 1) & mask);
      end
      res = refout ? rev_n(r, w) : r;
    end else begin
      rp = rev_n(poly & mask, w);
      r  = rev_n(init & mask, w);
      foreach (fbytes[k]) begin
        r = r ^ 32'(fbytes[k]);
        for (int b = 0; b < 8; b++)
          r = ((r & 32'd1) != 0) ? ((r >> 1) ^ rp) : (r >> 1);
      end
      res = refout ? r : rev_n(r, w);
    end
    return (res ^ xo) & mask;
  endfunction

  function automatic logic [31:0] exp_a();
    return model_crc(16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic logic [31:0] exp_b();
    return model_crc(16, 32'h8005, 32'h0, 32'h0, 1'b1, 1'b1);
  endfunction

  task automatic load_str(input string s);
    fbytes.delete();
    for (int i = 0; i < s.len(); i++) fbytes.push_back(s[i]);
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic drive_beat(input logic [7:0] d, input bit sof, input bit eof);
    int t;
    in_valid = 1'b1; in_data = d; in_sof = sof; in_eof = eof;
    t = 0;
    while (!a_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check_eq("beat_accept_timeout", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  // Hold out_ready low for `hold` cycles offering ignored beats, then release.
  task automatic release_out(input string tag, input int hold, input logic [15:0] crc_a);
    int e0;
    e0 = err_cnt;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1; in_data = 8'($urandom);
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 32'(a_out_valid), 32'd1);
      check_eq({tag, "_hold_crc"}, 32'(a_out_crc), 32'(crc_a));
      check_eq({tag, "_hold_ready"}, 32'(a_in_ready), 32'd0);
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_drop_valid"}, 32'(a_out_valid), 32'd0);
    check_eq({tag, "_ready_back"}, 32'(a_in_ready), 32'd1);
    if (hold > 0) check_eq({tag, "_hold_noerr"}, 32'(err_cnt), 32'(e0));
  endtask

  // Send fbytes as one frame on A/B, check results (optionally against constants).
  task automatic run_frame(input string tag, input bit gaps, input int hold,
                           input int ca, input int cb);
    int n;
    logic [15:0] ea;
    n = fbytes.size();
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      drive_beat(fbytes[k], k == 0, k == n - 1);
    end
    ea = 16'(exp_a());
    check_eq({tag, "_latency"}, 32'(a_out_valid), 32'd1);
    check_eq({tag, "_crc_a"}, 32'(a_out_crc), 32'(ea));
    check_eq({tag, "_crc_b"}, 32'(b_out_crc), exp_b());
    if (ca >= 0) check_eq({tag, "_const_a"}, 32'(a_out_crc), 32'(ca));
    if (cb >= 0) check_eq({tag, "_const_b"}, 32'(b_out_crc), 32'(cb));
`ifdef CRC_STREAM_CHECK_EN
    check_eq({tag, "_ok_a"}, 32'(a_out_ok), 32'(ea == 16'h0000));
`endif
    release_out(tag, hold, ea);
  endtask

  // 16-bit-beat frame on instance C; fbytes must hold an even count.
  task automatic run_frame16(input string tag);
    int n;
    int t;
    n = fbytes.size() / 2;
    for (int k = 0; k < n; k++) begin
      c_in_valid = 1'b1; c_in_data = {fbytes[2*k], fbytes[2*k+1]};
      c_in_sof = (k == 0); c_in_eof = (k == n - 1);
      t = 0;
      while (!c_in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) check_eq({tag, "_accept_timeout"}, 32'(c_in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      c_in_valid = 1'b0; c_in_sof = 1'b0; c_in_eof = 1'b0;
    end
    check_eq({tag, "_latency"}, 32'(c_out_valid), 32'd1);
    check_eq({tag, "_crc_c"}, 32'(c_out_crc), exp_a());
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
    check_eq({tag, "_drop_valid"}, 32'(c_out_valid), 32'd0);
  endtask

  initial begin
    int e0;
    int n;
    string s;

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(a_in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_out_crc", 32'(a_out_crc), 32'd0);
    check_eq("rst_frame_err", 32'(a_frame_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(a_in_ready), 32'd1);

    // Check string and a single zero byte with extended backpressure.
    load_str("123456789");
    run_frame("t1", 1'b0, 0, 32'h29B1, 32'hBB3D);
    fbytes.delete(); fbytes.push_back(8'h00);
    run_frame("t2", 1'b0, 5, 32'hE1F0, -1);

    // 16-bit beats give the same CRC as the byte-wise model.
    load_str("12345678");
    run_frame16("t4");
    for (int f = 0; f < 5; f++) begin
      fbytes.delete();
      n = 2 * int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) fbytes.push_back(8'($urandom));
      run_frame16($sformatf("c_rand%0d", f));
    end

    // Mid-frame sof abandons the open frame.
    e0 = err_cnt;
    load_str("1234");
    for (int k = 0; k < 4; k++) drive_beat(fbytes[k], k == 0, 1'b0);
    load_str("123456789");
    run_frame("t5", 1'b0, 0, 32'h29B1, 32'hBB3D);
    check_eq("t5_err_once", 32'(err_cnt), 32'(e0 + 1));

    // Non-sof beat in IDLE is dropped and flagged.
    e0 = err_cnt;
    drive_beat(8'h55, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("idle_nonsof_err", 32'(err_cnt), 32'(e0 + 1));
    check_eq("idle_nonsof_novalid", 32'(a_out_valid), 32'd0);

    // Randomized frames with input gaps and output backpressure.
    e0 = err_cnt;
    for (int f = 0; f < 40; f++) begin
      fbytes.delete();
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) fbytes.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", f), 1'b1, int'($urandom_range(0, 3)), -1, -1);
    end
    check_eq("rand_no_err", 32'(err_cnt), 32'(e0));

    // Reset mid-frame discards everything.
    load_str("abc");
    for (int k = 0; k < 3; k++) drive_beat(fbytes[k], k == 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_mid_ready", 32'(a_in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    load_str("123456789");
    run_frame("t6_after_rst", 1'b0, 0, 32'h29B1, 32'hBB3D);

    // Reset while holding a result.
    load_str("xyz");
    for (int k = 0; k < 3; k++) drive_beat(fbytes[k], k == 0, k == 2);
    check_eq("hold_before_rst", 32'(a_out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_hold_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_hold_crc", 32'(a_out_crc), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    load_str("123456789");
    run_frame("after_hold_rst", 1'b1, 1, 32'h29B1, 32'hBB3D);

`ifdef CRC_STREAM_CHECK_EN
    // Frames carrying their own CRC.
    s = "123456789";
    load_str(s); fbytes.push_back(8'h29); fbytes.push_back(8'hB1);
    run_frame("t6_ok", 1'b0, 0, -1, -1);
    check_eq("t6_ok_model", exp_a(), 32'h0);
    load_str(s); fbytes.push_back(8'h29); fbytes.push_back(8'hB0);
    run_frame("t6_bad", 1'b0, 0, -1, -1);
`else
    s = "";
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
